// File: rtl/lsu_sram_bridge_if.sv
// Core-side and controller-side signal bundles for the LSU/SRAM bridge.
// Latency: none (wiring only).
// Backpressure: the core holds a request until lsu_done; the controller answers each strobe with ACK.
//
// lsu_req_if   : core memory stage <-> bridge. master = core, slave = bridge.
//   lsu_addr/lsu_wdata/lsu_funct3/lsu_rden/lsu_wren  request (held until lsu_done)
//   lsu_rdata/lsu_done/lsu_err/lsu_stall             response
// sram_ctrl_if : bridge <-> IS61WV25616 controller. master = bridge, slave = controller.
//   ADDR/WDATA/BMASK/WREN/RDEN                       request, strobes one cycle wide
//   RDATA/ACK                                        response

interface lsu_req_if;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_funct3;
    logic        lsu_rden;
    logic        lsu_wren;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        lsu_stall;

    modport master (
        output lsu_addr, lsu_wdata, lsu_funct3, lsu_rden, lsu_wren,
        input  lsu_rdata, lsu_done, lsu_err, lsu_stall
    );

    modport slave (
        input  lsu_addr, lsu_wdata, lsu_funct3, lsu_rden, lsu_wren,
        output lsu_rdata, lsu_done, lsu_err, lsu_stall
    );
endinterface

interface sram_ctrl_if;
    logic [17:0] ADDR;
    logic [31:0] WDATA;
    logic [3:0]  BMASK;
    logic        WREN;
    logic        RDEN;
    logic [31:0] RDATA;
    logic        ACK;

    modport master (
        output ADDR, WDATA, BMASK, WREN, RDEN,
        input  RDATA, ACK
    );

    modport slave (
        input  ADDR, WDATA, BMASK, WREN, RDEN,
        output RDATA, ACK
    );
endinterface

// File: rtl/lsu_sram_bridge.sv
// RV32 load/store front-end for the 32-bit SRAM controller: range/alignment/funct3 checks, lane formatting.
// Latency: strobe 1 cycle after the request is seen; done 1 cycle after ACK; rejects complete in 1 cycle.
// Backpressure: lsu_stall holds the core until lsu_done; WAIT has no timeout and waits for ACK indefinitely.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   lsu  (slave)     core request/response bundle, see lsu_req_if
//   sram (master)    controller request/response bundle, see sram_ctrl_if

module lsu_sram_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    lsu_req_if.slave      lsu,
    sram_ctrl_if.master   sram
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;

    // Captured request context needed after IDLE
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;

    // Registered outputs
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;
    logic [17:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic        wren_q;
    logic        rden_q;

    // Request decode (values loaded into the registers when IDLE accepts)
    logic        req_any;
    logic        req_both;
    logic        out_of_range;
    logic        misaligned;
    logic        bad_funct3;
    logic        reject;
    logic [17:0] addr_d;
    logic [31:0] wdata_d;
    logic [3:0]  bmask_d;

    // Load formatting of controller data
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rdata_d;

    always_comb begin
        req_any      = lsu.lsu_rden | lsu.lsu_wren;
        req_both     = lsu.lsu_rden & lsu.lsu_wren;
        // Only the top bits select the 512 KiB window; the low 19 bits of ADDR_BASE are don't-care.
        out_of_range = (lsu.lsu_addr[31:19] != ADDR_BASE[31:19]);

        misaligned = 1'b0;
        case (lsu.lsu_funct3[1:0])
            2'b01:   misaligned = lsu.lsu_addr[0];
            2'b10:   misaligned = (lsu.lsu_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        bad_funct3 = 1'b0;
        if (lsu.lsu_rden) begin
            // Legal loads: LB LH LW LBU LHU
            case (lsu.lsu_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_funct3 = 1'b0;
                default:                                bad_funct3 = 1'b1;
            endcase
        end else begin
            // Legal stores: SB SH SW
            bad_funct3 = lsu.lsu_funct3[2] | (lsu.lsu_funct3[1:0] == 2'b11);
        end

        reject = req_both | out_of_range | misaligned | bad_funct3;

        // Controller addresses 16-bit halfwords; accesses are always word-wide with a byte mask.
        addr_d = {lsu.lsu_addr[18:2], 1'b0};

        wdata_d = lsu.lsu_wdata;
        bmask_d = 4'b1111;
        if (!lsu.lsu_rden) begin
            case (lsu.lsu_funct3[1:0])
                2'b00: begin
                    wdata_d = {4{lsu.lsu_wdata[7:0]}};
                    bmask_d = 4'b0001 << lsu.lsu_addr[1:0];
                end
                2'b01: begin
                    wdata_d = {2{lsu.lsu_wdata[15:0]}};
                    bmask_d = lsu.lsu_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_d = lsu.lsu_wdata;
                    bmask_d = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        rd_byte = sram.RDATA[7:0];
        case (lane_q)
            2'd0: rd_byte = sram.RDATA[7:0];
            2'd1: rd_byte = sram.RDATA[15:8];
            2'd2: rd_byte = sram.RDATA[23:16];
            2'd3: rd_byte = sram.RDATA[31:24];
            default: rd_byte = sram.RDATA[7:0];
        endcase
        rd_half = lane_q[1] ? sram.RDATA[31:16] : sram.RDATA[15:0];

        case (funct3_q)
            3'b000:  rdata_d = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rdata_d = {24'd0, rd_byte};
            3'b001:  rdata_d = {{16{rd_half[15]}}, rd_half};
            3'b101:  rdata_d = {16'd0, rd_half};
            default: rdata_d = sram.RDATA;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            lane_q    <= 2'd0;
            funct3_q  <= 3'd0;
            is_load_q <= 1'b0;
            rdata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= 18'd0;
            wdata_q   <= 32'd0;
            bmask_q   <= 4'd0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        lane_q    <= lsu.lsu_addr[1:0];
                        funct3_q  <= lsu.lsu_funct3;
                        is_load_q <= lsu.lsu_rden;
                        if (reject) begin
                            // Rejected requests never touch the controller.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            rdata_q <= 32'd0;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= addr_d;
                            bmask_q <= bmask_d;
                            // Loads leave the last store data on the bus.
                            if (!lsu.lsu_rden) begin
                                wdata_q <= wdata_d;
                            end
                            wren_q  <= lsu.lsu_wren;
                            rden_q  <= lsu.lsu_rden;
                            state_q <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // Strobe was visible for exactly this cycle; address/data/mask stay put.
                    wren_q  <= 1'b0;
                    rden_q  <= 1'b0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (sram.ACK) begin
                        rdata_q <= is_load_q ? rdata_d : 32'd0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    // Requests are not sampled here; a held request is taken next cycle in IDLE.
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lsu.lsu_rdata = rdata_q;
    assign lsu.lsu_done  = done_q;
    assign lsu.lsu_err   = err_q;
    assign lsu.lsu_stall = (lsu.lsu_rden | lsu.lsu_wren) & ~done_q;

    assign sram.ADDR  = addr_q;
    assign sram.WDATA = wdata_q;
    assign sram.BMASK = bmask_q;
    assign sram.WREN  = wren_q;
    assign sram.RDEN  = rden_q;

    // Strobes are mutually exclusive and single-cycle; done is a single-cycle pulse.
    a_strobe_excl: assert property (@(posedge i_clk) disable iff (i_reset) !(wren_q && rden_q));
    a_wren_pulse:  assert property (@(posedge i_clk) disable iff (i_reset) wren_q |=> !wren_q);
    a_rden_pulse:  assert property (@(posedge i_clk) disable iff (i_reset) rden_q |=> !rden_q);
    a_done_pulse:  assert property (@(posedge i_clk) disable iff (i_reset) done_q |=> !done_q);

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Self-checking bench for lsu_sram_bridge with a behavioural SRAM controller and byte-level reference memory.
// Latency: controller acks stores 2 cycles and loads 5 cycles after the strobe.
// Backpressure: the bench holds each request until done, then issues the next one back-to-back or after a gap.

module tb_lsu_sram_bridge;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic rst;

    lsu_req_if   lsu ();
    sram_ctrl_if sram ();

    lsu_sram_bridge #(.ADDR_BASE(BASE)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .lsu     (lsu),
        .sram    (sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural controller ----------------
    logic [31:0] cmem [int];
    int          pend_cnt;
    logic [31:0] pend_rdata;
    logic        force_ack;

    initial begin
        sram.ACK   = 1'b0;
        sram.RDATA = 32'd0;
        pend_cnt   = 0;
        pend_rdata = 32'd0;
        force_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_cnt = 0;
            end else if (sram.WREN) begin
                logic [31:0] w;
                int idx;
                idx = int'(sram.ADDR[17:1]);
                w = cmem.exists(idx) ? cmem[idx] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (sram.BMASK[i]) w[8*i +: 8] = sram.WDATA[8*i +: 8];
                cmem[idx] = w;
                pend_cnt = 2;
            end else if (sram.RDEN) begin
                int idx;
                idx = int'(sram.ADDR[17:1]);
                pend_rdata = cmem.exists(idx) ? cmem[idx] : 32'd0;
                pend_cnt = 5;
            end
            @(posedge clk);
            #2;
            sram.ACK = force_ack;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    sram.ACK   = 1'b1;
                    sram.RDATA = pend_rdata;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] rmem [int];

    function automatic logic [7:0] ref_byte(input int a);
        return rmem.exists(a) ? rmem[a] : 8'd0;
    endfunction

    function automatic bit f3_legal(input bit rd, input logic [2:0] f3);
        if (rd) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    task automatic run_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input string tag, output logic [31:0] got);
        bit          exp_err;
        int          size;
        int          exp_done;
        int          base;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;
        logic [3:0]  exp_bm;
        logic [17:0] exp_addr;
        int          done_k;
        int          nstrobe;
        int          strobe_k;
        logic [17:0] s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_bm;
        logic        s_wr;
        logic        got_err;

        size    = 1 << f3[1:0];
        exp_err = (rd && wr) || (a[31:19] != BASE[31:19]) || ((a % size) != 0) || !f3_legal(rd, f3);
        base    = int'(a[18:0]);
        exp_addr = 18'((a[18:0] >> 2) << 1);
        if (size == 1)      exp_wd = {4{wd[7:0]}};
        else if (size == 2) exp_wd = {2{wd[15:0]}};
        else                exp_wd = wd;
        exp_bm = rd ? 4'hF : 4'(((1 << size) - 1) << (a % 4));
        exp_rdata = 32'd0;
        if (rd && !exp_err) begin
            for (int i = 0; i < size; i++) exp_rdata[8*i +: 8] = ref_byte(base + i);
            if (!f3[2] && size == 1) exp_rdata = {{24{exp_rdata[7]}}, exp_rdata[7:0]};
            if (!f3[2] && size == 2) exp_rdata = {{16{exp_rdata[15]}}, exp_rdata[15:0]};
        end
        exp_done = exp_err ? 1 : (rd ? 7 : 4);

        lsu.lsu_addr   = a;
        lsu.lsu_wdata  = wd;
        lsu.lsu_funct3 = f3;
        lsu.lsu_rden   = rd;
        lsu.lsu_wren   = wr;

        done_k = -1; nstrobe = 0; strobe_k = -1; got = 32'd0; got_err = 1'b0;
        s_addr = '0; s_wd = '0; s_bm = '0; s_wr = 1'b0;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (sram.WREN || sram.RDEN) begin
                nstrobe++;
                strobe_k = k;
                s_addr = sram.ADDR; s_wd = sram.WDATA; s_bm = sram.BMASK; s_wr = sram.WREN;
            end
            check_val({tag, ".stall"}, 32'(lsu.lsu_stall), 32'(!lsu.lsu_done));
            if (lsu.lsu_done) begin
                done_k  = k;
                got_err = lsu.lsu_err;
                got     = lsu.lsu_rdata;
            end
        end

        check_val({tag, ".lat"}, 32'(done_k), 32'(exp_done));
        check_val({tag, ".err"}, 32'(got_err), 32'(exp_err));
        if (rd || exp_err) check_val({tag, ".rdata"}, got, exp_rdata);
        check_val({tag, ".nstrobe"}, 32'(nstrobe), exp_err ? 32'd0 : 32'd1);
        if (!exp_err && nstrobe == 1) begin
            check_val({tag, ".strobe_cyc"}, 32'(strobe_k), 32'd1);
            check_val({tag, ".dir"}, 32'(s_wr), 32'(wr));
            check_val({tag, ".addr"}, 32'(s_addr), 32'(exp_addr));
            check_val({tag, ".bmask"}, 32'(s_bm), 32'(exp_bm));
            if (wr) check_val({tag, ".wdata"}, s_wd, exp_wd);
        end

        if (wr && !exp_err) begin
            for (int i = 0; i < 4; i++)
                if (exp_bm[i]) rmem[(base & ~3) + i] = exp_wd[8*i +: 8];
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        lsu.lsu_rden = 1'b0;
        lsu.lsu_wren = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_val({tag, ".quiet"}, {30'd0, sram.WREN | sram.RDEN, lsu.lsu_done}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".rdata"}, lsu.lsu_rdata, 32'd0);
        check_val({tag, ".ctl"}, {29'd0, lsu.lsu_done, lsu.lsu_err, sram.WREN | sram.RDEN}, 32'd0);
        check_val({tag, ".addr"}, 32'(sram.ADDR), 32'd0);
        check_val({tag, ".wdata"}, sram.WDATA, 32'd0);
        check_val({tag, ".bmask"}, 32'(sram.BMASK), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        rst = 1'b1;
        lsu.lsu_addr = 32'd0; lsu.lsu_wdata = 32'd0; lsu.lsu_funct3 = 3'd0;
        lsu.lsu_rden = 1'b0;  lsu.lsu_wren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;

        // Directed store then loads of the same word
        run_req(0, 1, 32'h104, 32'hDEAD_BEEF, 3'b010, "SW104", got);
        run_req(1, 0, 32'h107, 32'h0, 3'b000, "LB107", got);
        check_val("LB107.val", got, 32'hFFFF_FFDE);
        run_req(1, 0, 32'h107, 32'h0, 3'b100, "LBU107", got);
        check_val("LBU107.val", got, 32'h0000_00DE);
        run_req(1, 0, 32'h106, 32'h0, 3'b001, "LH106", got);
        check_val("LH106.val", got, 32'hFFFF_DEAD);
        run_req(1, 0, 32'h104, 32'h0, 3'b101, "LHU104", got);
        check_val("LHU104.val", got, 32'h0000_BEEF);
        idle(2, "gap1");

        run_req(0, 1, 32'h105, 32'h1234_5655, 3'b000, "SB105", got);
        run_req(0, 1, 32'h106, 32'h0000_A5A5, 3'b001, "SH106", got);
        run_req(1, 0, 32'h104, 32'h0, 3'b010, "LW104", got);
        check_val("LW104.val", got, 32'hA5A5_55EF);

        // Rejected requests
        run_req(1, 0, 32'h102, 32'h0, 3'b010, "LWmis", got);
        run_req(1, 0, 32'h101, 32'h0, 3'b001, "LHmis", got);
        run_req(0, 1, 32'h0008_0000, 32'h1111_2222, 3'b010, "SWrange", got);
        run_req(1, 0, 32'h104, 32'h0, 3'b011, "Lf3", got);
        run_req(1, 1, 32'h104, 32'h0, 3'b010, "RdWr", got);
        idle(2, "gap2");

        // Reset while a load is waiting for its ack
        lsu.lsu_addr = 32'h104; lsu.lsu_funct3 = 3'b010; lsu.lsu_rden = 1'b1; lsu.lsu_wren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        lsu.lsu_rden = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("rstwait");
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        idle(6, "spurious");
        run_req(1, 0, 32'h104, 32'h0, 3'b010, "LWpost", got);
        check_val("LWpost.val", got, 32'hA5A5_55EF);

        // Alternating store/load stream, back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = $urandom;
            run_req(0, 1, 32'h300 + 32'(4 * i), d, 3'b010, "streamSW", got);
            run_req(1, 0, 32'h300 + 32'(4 * i), 32'h0, 3'b010, "streamLW", got);
            check_val("streamLW.val", got, d);
        end
        idle(1, "gap3");

        // Randomized mix of legal and illegal requests
        for (int i = 0; i < 200; i++) begin
            int r;
            bit rd, wr;
            logic [31:0] a;
            logic [2:0]  f3;
            r  = $urandom_range(0, 9);
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'h200 + 32'($urandom_range(0, 31));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)) | (rd ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000);
            run_req(rd, wr, a, $urandom, f3, "rand", got);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "randgap");
        end
        idle(2, "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
